// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one outstanding main-memory request between icache and dcache misses.
// Request word is {addr, is_store, data}; define ARB_ROUND_ROBIN_EN for round-robin ties (default: dcache wins).
module memory_arbiter #(
    parameter int MEM_LAT_W = 4,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   icache_req_valid,
    input  logic [ADDR_W+LINE_W:0] icache_req_info,
    output logic                   icache_rsp_valid,
    output logic [LINE_W-1:0]      icache_rsp_data,
    input  logic                   dcache_req_valid,
    input  logic [ADDR_W+LINE_W:0] dcache_req_info,
    output logic                   dcache_rsp_valid,
    output logic [LINE_W-1:0]      dcache_rsp_data,
    output logic                   mem_req_valid,
    output logic [ADDR_W+LINE_W:0] mem_req_info,
    input  logic                   mem_rsp_valid,
    input  logic [LINE_W-1:0]      mem_rsp_data,
    output logic [MEM_LAT_W-1:0]   busy_cycles
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic ipend_q, ipend_d, dpend_q, dpend_d, owner_q, owner_d;
    logic [ADDR_W+LINE_W:0] ireq_q, ireq_d, dreq_q, dreq_d, mem_req_info_q, mem_req_info_d;
    logic mem_req_valid_q, mem_req_valid_d, irsp_valid_q, irsp_valid_d, drsp_valid_q, drsp_valid_d;
    logic [LINE_W-1:0] irsp_data_q, irsp_data_d, drsp_data_q, drsp_data_d;
    logic [MEM_LAT_W-1:0] busy_q, busy_d;
    logic ikeep, dkeep, go, pick;

    always_comb begin
        // the owner's pending flag drops in its RESP cycle, so a same-cycle request is captured
        ikeep = ipend_q && !(state_q == RESP && !owner_q);
        dkeep = dpend_q && !(state_q == RESP && owner_q);
        ipend_d = ikeep || icache_req_valid;
        dpend_d = dkeep || dcache_req_valid;
        ireq_d = ikeep || !icache_req_valid ? ireq_q : icache_req_info;
        dreq_d = dkeep || !dcache_req_valid ? dreq_q : dcache_req_info;
`ifdef ARB_ROUND_ROBIN_EN
        // owner_q still names the last granted port while IDLE
        pick = ipend_q && dpend_q ? !owner_q : dpend_q;
`else
        pick = dpend_q;
`endif
        go = state_q == IDLE && (ipend_q || dpend_q);
        owner_d = go ? pick : owner_q;
        state_d = state_q == IDLE  ? (go ? ISSUE : IDLE) :
                  state_q == ISSUE ? WAIT :
                  state_q == WAIT  ? (mem_rsp_valid ? RESP : WAIT) : IDLE;
        mem_req_valid_d = go;
        mem_req_info_d = go ? (pick ? dreq_q : ireq_q) : mem_req_info_q;
        irsp_valid_d = state_q == WAIT && mem_rsp_valid && !owner_q;
        drsp_valid_d = state_q == WAIT && mem_rsp_valid && owner_q;
        irsp_data_d = irsp_valid_d ? mem_rsp_data : irsp_data_q;
        drsp_data_d = drsp_valid_d ? mem_rsp_data : drsp_data_q;
        busy_d = state_q != WAIT ? '0 : &busy_q ? busy_q : busy_q + MEM_LAT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            ipend_q         <= 1'b0;
            dpend_q         <= 1'b0;
            owner_q         <= 1'b0;
            ireq_q          <= '0;
            dreq_q          <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_info_q  <= '0;
            irsp_valid_q    <= 1'b0;
            drsp_valid_q    <= 1'b0;
            irsp_data_q     <= '0;
            drsp_data_q     <= '0;
            busy_q          <= '0;
        end else begin
            state_q         <= state_d;
            ipend_q         <= ipend_d;
            dpend_q         <= dpend_d;
            owner_q         <= owner_d;
            ireq_q          <= ireq_d;
            dreq_q          <= dreq_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_info_q  <= mem_req_info_d;
            irsp_valid_q    <= irsp_valid_d;
            drsp_valid_q    <= drsp_valid_d;
            irsp_data_q     <= irsp_data_d;
            drsp_data_q     <= drsp_data_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_req_valid    = mem_req_valid_q;
    assign mem_req_info     = mem_req_info_q;
    assign icache_rsp_valid = irsp_valid_q;
    assign icache_rsp_data  = irsp_data_q;
    assign dcache_rsp_valid = drsp_valid_q;
    assign dcache_rsp_data  = drsp_data_q;
    assign busy_cycles      = busy_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus a randomized run against a transaction-level arbiter model.
module tb_memory_arbiter;
    localparam int AW = 32, LW = 32, RW = AW + LW + 1;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b1;
    logic icache_req_valid = 1'b0, dcache_req_valid = 1'b0, mem_rsp_valid = 1'b0;
    logic [RW-1:0] icache_req_info = '0, dcache_req_info = '0;
    logic [LW-1:0] mem_rsp_data = '0;
    logic icache_rsp_valid, dcache_rsp_valid, mem_req_valid;
    logic [LW-1:0] icache_rsp_data, dcache_rsp_data;
    logic [RW-1:0] mem_req_info;
    logic [3:0] busy_cycles;
    int vectors = 0, miscompares = 0;

    memory_arbiter #(.MEM_LAT_W(4), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clock(clock), .reset(reset),
        .icache_req_valid(icache_req_valid), .icache_req_info(icache_req_info),
        .icache_rsp_valid(icache_rsp_valid), .icache_rsp_data(icache_rsp_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_info(dcache_req_info),
        .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_data(dcache_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_info(mem_req_info),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy_cycles(busy_cycles)
    );

    always #5 clock = ~clock;

    function automatic logic [RW-1:0] mk(input logic [AW-1:0] a, input logic st, input logic [LW-1:0] d);
        return {a, st, d};
    endfunction

    task automatic idle_inputs();
        icache_req_valid = 1'b0;
        dcache_req_valid = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            icache_req_valid = 1'($urandom);
            dcache_req_valid = 1'($urandom);
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data = $urandom;
            icache_req_info = mk($urandom, 1'b0, $urandom);
            dcache_req_info = mk($urandom, 1'b1, $urandom);
            @(negedge clock);
        end
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        vectors++; if (mem_req_info !== '0) begin miscompares++; $display("FAIL reset_mem_req_info: got %h want 0", mem_req_info); end
        vectors++; if (icache_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_icache_rsp_valid: got %b want 0", icache_rsp_valid); end
        vectors++; if (dcache_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dcache_rsp_valid: got %b want 0", dcache_rsp_valid); end
        vectors++; if (icache_rsp_data !== '0) begin miscompares++; $display("FAIL reset_icache_rsp_data: got %h want 0", icache_rsp_data); end
        vectors++; if (dcache_rsp_data !== '0) begin miscompares++; $display("FAIL reset_dcache_rsp_data: got %h want 0", dcache_rsp_data); end
        vectors++; if (busy_cycles !== 4'd0) begin miscompares++; $display("FAIL reset_busy_cycles: got %0d want 0", busy_cycles); end
        reset = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clock);
        vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_pending: got mem_req_valid %b want 0", mem_req_valid); end
    endtask

    task automatic test_single();
        int lat, peak;
        do_reset();
        icache_req_valid = 1'b1;
        icache_req_info = mk(32'h0000_1000, 1'b0, '0);
        lat = 0;
        do begin
            @(negedge clock);
            icache_req_valid = 1'b0;
            lat++;
        end while (!mem_req_valid && lat < 10);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL single_req_latency: got %0d want 2", lat); end
        vectors++; if (mem_req_info !== mk(32'h0000_1000, 1'b0, '0)) begin miscompares++; $display("FAIL single_req_info: got %h want %h", mem_req_info, mk(32'h0000_1000, 1'b0, '0)); end
        peak = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            mem_rsp_valid = k == 3;
            mem_rsp_data = 32'hA5A5_A5A5;
            if (busy_cycles > peak) peak = busy_cycles;
            vectors++; if (icache_rsp_valid !== (k == 4)) begin miscompares++; $display("FAIL single_rsp_valid_k%0d: got %b want %b", k, icache_rsp_valid, k == 4); end
        end
        vectors++; if (icache_rsp_data !== 32'hA5A5_A5A5) begin miscompares++; $display("FAIL single_rsp_data: got %h want a5a5a5a5", icache_rsp_data); end
        vectors++; if (dcache_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_dcache_quiet: got %b want 0", dcache_rsp_valid); end
        @(negedge clock);
        vectors++; if (peak !== 3) begin miscompares++; $display("FAIL single_busy_peak: got %0d want 3", peak); end
        vectors++; if (busy_cycles !== 4'd0) begin miscompares++; $display("FAIL single_busy_clear: got %0d want 0", busy_cycles); end
        vectors++; if (icache_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_rsp_one_pulse: got %b want 0", icache_rsp_valid); end
    endtask

    task automatic test_tie();
        logic [AW-1:0] got[$];
        logic [AW-1:0] exp[3];
        logic [AW-1:0] cur;
        int resp_at, ip, dp;
        bit again;
        exp = RR ? '{32'h200, 32'h100, 32'h240} : '{32'h200, 32'h240, 32'h100};
        cur = '0; resp_at = -1; ip = 0; dp = 0; again = 1'b0;
        do_reset();
        icache_req_valid = 1'b1; icache_req_info = mk(32'h100, 1'b0, '0);
        dcache_req_valid = 1'b1; dcache_req_info = mk(32'h200, 1'b0, '0);
        for (int it = 0; it < 40; it++) begin
            @(negedge clock);
            icache_req_valid = 1'b0;
            dcache_req_valid = 1'b0;
            if (mem_req_valid) begin
                cur = mem_req_info[RW-1 -: AW];
                got.push_back(cur);
                resp_at = it + 2;
            end
            mem_rsp_valid = it == resp_at;
            mem_rsp_data = ~cur;
            if (icache_rsp_valid) begin
                ip++;
                vectors++; if (icache_rsp_data !== ~32'h100) begin miscompares++; $display("FAIL tie_icache_data: got %h want %h", icache_rsp_data, ~32'h100); end
            end
            if (dcache_rsp_valid) begin
                dp++;
                vectors++; if (dcache_rsp_data !== ~cur) begin miscompares++; $display("FAIL tie_dcache_data: got %h want %h", dcache_rsp_data, ~cur); end
                if (!again) begin
                    again = 1'b1;
                    dcache_req_valid = 1'b1;
                    dcache_req_info = mk(32'h240, 1'b0, '0);
                end
            end
        end
        vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL tie_grant_count: got %0d want 3", got.size()); end
        while (got.size() < 3) got.push_back('x);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL tie_grant_%0d: got %h want %h", i, got[i], exp[i]); end
        end
        vectors++; if (ip !== 1) begin miscompares++; $display("FAIL tie_icache_pulses: got %0d want 1", ip); end
        vectors++; if (dp !== 2) begin miscompares++; $display("FAIL tie_dcache_pulses: got %0d want 2", dp); end
    endtask

    task automatic test_store();
        int reqs, ip, dp, resp_at;
        reqs = 0; ip = 0; dp = 0; resp_at = -1;
        do_reset();
        dcache_req_valid = 1'b1;
        dcache_req_info = mk(32'h300, 1'b1, 32'h1234);
        for (int it = 0; it < 15; it++) begin
            @(negedge clock);
            dcache_req_valid = 1'b0;
            if (mem_req_valid) begin
                reqs++;
                resp_at = it + 1;
                vectors++; if (mem_req_info !== mk(32'h300, 1'b1, 32'h1234)) begin miscompares++; $display("FAIL store_req_info: got %h want %h", mem_req_info, mk(32'h300, 1'b1, 32'h1234)); end
            end
            mem_rsp_valid = it == resp_at;
            mem_rsp_data = $urandom;
            ip += int'(icache_rsp_valid);
            dp += int'(dcache_rsp_valid);
        end
        vectors++; if (reqs !== 1) begin miscompares++; $display("FAIL store_req_pulses: got %0d want 1", reqs); end
        vectors++; if (dp !== 1) begin miscompares++; $display("FAIL store_ack_pulses: got %0d want 1", dp); end
        vectors++; if (ip !== 0) begin miscompares++; $display("FAIL store_icache_quiet: got %0d want 0", ip); end
    endtask

    task automatic test_reset_mid();
        int n, rv, mr, bz;
        rv = 0; mr = 0; bz = 0; n = 0;
        do_reset();
        icache_req_valid = 1'b1;
        icache_req_info = mk(32'h500, 1'b0, '0);
        do begin
            @(negedge clock);
            icache_req_valid = 1'b0;
            n++;
        end while (!mem_req_valid && n < 10);
        vectors++; if (!mem_req_valid) begin miscompares++; $display("FAIL resetmid_issue_timeout: got 0 want 1"); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = $urandom;
            @(negedge clock);
            rv += int'(icache_rsp_valid || dcache_rsp_valid);
            mr += int'(mem_req_valid);
            bz += int'(busy_cycles != 4'd0);
        end
        mem_rsp_valid = 1'b0;
        vectors++; if (rv !== 0) begin miscompares++; $display("FAIL resetmid_rsp_pulses: got %0d want 0", rv); end
        vectors++; if (mr !== 0) begin miscompares++; $display("FAIL resetmid_reissue: got %0d want 0", mr); end
        vectors++; if (bz !== 0) begin miscompares++; $display("FAIL resetmid_busy: got %0d nonzero cycles want 0", bz); end
    endtask

    task automatic test_saturate();
        int n, peak;
        n = 0; peak = 0;
        do_reset();
        dcache_req_valid = 1'b1;
        dcache_req_info = mk(32'h400, 1'b0, '0);
        do begin
            @(negedge clock);
            dcache_req_valid = 1'b0;
            n++;
        end while (!mem_req_valid && n < 10);
        vectors++; if (!mem_req_valid) begin miscompares++; $display("FAIL sat_issue_timeout: got 0 want 1"); end
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            mem_rsp_valid = k == 20;
            mem_rsp_data = 32'hC3C3_3C3C;
            if (busy_cycles > peak) peak = busy_cycles;
        end
        vectors++; if (dcache_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL sat_rsp_valid: got %b want 1", dcache_rsp_valid); end
        vectors++; if (dcache_rsp_data !== 32'hC3C3_3C3C) begin miscompares++; $display("FAIL sat_rsp_data: got %h want c3c33c3c", dcache_rsp_data); end
        vectors++; if (busy_cycles !== 4'd15) begin miscompares++; $display("FAIL sat_busy_final: got %0d want 15", busy_cycles); end
        vectors++; if (peak !== 15) begin miscompares++; $display("FAIL sat_busy_peak: got %0d want 15", peak); end
    endtask

    task automatic test_random();
        bit pend[2], p1[2], p2[2], out, last, pick, want;
        logic [RW-1:0] info[2], i1[2], i2[2];
        logic [LW-1:0] exp_data[2], rd;
        int p_iter, lat, free_at, b;
        do_reset();
        pend = '{0, 0}; p1 = '{0, 0}; p2 = '{0, 0};
        info = '{'0, '0}; i1 = '{'0, '0}; i2 = '{'0, '0};
        exp_data = '{'0, '0};
        out = 0; last = 0; pick = 0; p_iter = 0; lat = 0; free_at = 0; rd = '0;
        for (int it = 0; it < 800; it++) begin
            @(negedge clock);
            want = !out && it >= free_at && (p2[0] || p2[1]);
            vectors++; if (mem_req_valid !== want) begin miscompares++; $display("FAIL rnd_mem_req_valid@%0d: got %b want %b", it, mem_req_valid, want); end
            if (want) begin
                pick = p2[0] && p2[1] ? (RR ? !last : 1'b1) : p2[1];
                vectors++; if (mem_req_info !== i2[pick]) begin miscompares++; $display("FAIL rnd_mem_req_info@%0d: got %h want %h", it, mem_req_info, i2[pick]); end
                out = 1; last = pick; p_iter = it;
                lat = $urandom_range(1, 6);
                rd = $urandom;
            end
            b = out ? it - p_iter - 1 : 0;
            b = b < 0 ? 0 : b > 15 ? 15 : b;
            vectors++; if (busy_cycles !== 4'(b)) begin miscompares++; $display("FAIL rnd_busy@%0d: got %0d want %0d", it, busy_cycles, b); end
            want = out && it == p_iter + lat + 1;
            vectors++; if (icache_rsp_valid !== (want && !pick)) begin miscompares++; $display("FAIL rnd_icache_rsp_valid@%0d: got %b want %b", it, icache_rsp_valid, want && !pick); end
            vectors++; if (dcache_rsp_valid !== (want && pick)) begin miscompares++; $display("FAIL rnd_dcache_rsp_valid@%0d: got %b want %b", it, dcache_rsp_valid, want && pick); end
            if (want) begin
                exp_data[pick] = rd;
                pend[pick] = 0;
                out = 0;
                free_at = it + 2;
            end
            vectors++; if (icache_rsp_data !== exp_data[0]) begin miscompares++; $display("FAIL rnd_icache_rsp_data@%0d: got %h want %h", it, icache_rsp_data, exp_data[0]); end
            vectors++; if (dcache_rsp_data !== exp_data[1]) begin miscompares++; $display("FAIL rnd_dcache_rsp_data@%0d: got %h want %h", it, dcache_rsp_data, exp_data[1]); end
            if (out && it == p_iter + lat) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data = rd;
            end else begin
                mem_rsp_valid = (!out || it == p_iter) && $urandom_range(3) == 0;
                mem_rsp_data = $urandom;
            end
            icache_req_valid = $urandom_range(2) == 0;
            icache_req_info = mk($urandom, 1'b0, $urandom);
            dcache_req_valid = $urandom_range(2) == 0;
            dcache_req_info = mk($urandom, 1'($urandom), $urandom);
            if (icache_req_valid && !pend[0]) begin pend[0] = 1; info[0] = icache_req_info; end
            if (dcache_req_valid && !pend[1]) begin pend[1] = 1; info[1] = dcache_req_info; end
            p2 = p1; i2 = i1;
            p1 = pend; i1 = info;
        end
        idle_inputs();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_tie();
        test_store();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
